// File: rtl/clk_ratio_detect_pkg.sv
// Shared types and default sizing for the clock-ratio detector.
package clk_ratio_pkg;

    localparam int DEFAULT_B          = 16;
    localparam int DEFAULT_LOCK_COUNT = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FIRST = 2'd1,
        TRACK = 2'd2
    } state_e;

endpackage

// File: rtl/clk_ratio_detect_bit_synchronizer.sv
// Two-flop single-bit synchronizer with synchronous active-low reset.
// Only present when CLK_RATIO_DETECT_SYNC_EN is defined, the only build that uses it.
`ifdef CLK_RATIO_DETECT_SYNC_EN
module bit_synchronizer (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule
`endif

// File: rtl/clk_ratio_detect.sv
// Measures period and high time of sig_in in clkin cycles, tracks lock and no-edge timeout.
// Define CLK_RATIO_DETECT_SYNC_EN to route sig_in through a two-flop synchronizer.
module clk_ratio_detect
    import clk_ratio_pkg::*;
#(
    parameter int B          = DEFAULT_B,
    parameter int LOCK_COUNT = DEFAULT_LOCK_COUNT,
    parameter int TIMEOUT    = 2**B - 1
) (
    input  logic         clkin,
    input  logic         reset,
    input  logic         sig_in,
    output logic [B-1:0] ratio,
    output logic [B-1:0] high_count,
    output logic         valid,
    output logic         locked,
    output logic         timeout
);

    localparam int            CNT_MAX_INT       = 2**B - 1;
    localparam logic [B-1:0]  CNT_MAX           = '1;
    localparam logic [B-1:0]  CNT_ONE           = B'(1);
    localparam logic [B-1:0]  TIMEOUT_CNT       = B'(TIMEOUT);
    localparam logic          TIMEOUT_REACHABLE = (TIMEOUT <= CNT_MAX_INT);
    localparam int            MW                = $clog2(LOCK_COUNT + 1);
    localparam logic [MW-1:0] MATCH_MAX         = MW'(LOCK_COUNT);
    localparam logic [MW-1:0] MATCH_ONE         = MW'(1);

    logic          sig;
    logic          sigDly_q;
    logic          rise;
    logic          timeoutHit;

    state_e        state_q, state_d;
    logic [B-1:0]  cnt_q, cnt_d;
    logic [B-1:0]  hcnt_q, hcnt_d;
    logic [B-1:0]  ratio_q, ratio_d;
    logic [B-1:0]  highCount_q, highCount_d;
    logic [MW-1:0] matchCnt_q, matchCnt_d;
    logic          valid_q, valid_d;
    logic          locked_q, locked_d;
    logic          timeout_q, timeout_d;

    logic [B-1:0]  cntInc;
    logic [B-1:0]  hcntInc;
    logic [MW-1:0] matchInc;
    logic [MW-1:0] matchNext;

`ifdef CLK_RATIO_DETECT_SYNC_EN
    bit_synchronizer u_sync (
        .clk_i  (clkin),
        .rst_ni (reset),
        .d_i    (sig_in),
        .q_o    (sig)
    );
`else
    assign sig = sig_in;
`endif

    assign rise       = sig & ~sigDly_q;
    assign timeoutHit = TIMEOUT_REACHABLE && (cnt_q >= TIMEOUT_CNT);

    // Both counters stick at all-ones so an over-long period reads as the maximum.
    assign cntInc    = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_ONE;
    assign hcntInc   = (sig && (hcnt_q != CNT_MAX)) ? hcnt_q + CNT_ONE : hcnt_q;
    assign matchInc  = (matchCnt_q == MATCH_MAX) ? MATCH_MAX : matchCnt_q + MATCH_ONE;
    assign matchNext = (cnt_q == ratio_q) ? matchInc : MATCH_ONE;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hcnt_d      = hcnt_q;
        ratio_d     = ratio_q;
        highCount_d = highCount_q;
        matchCnt_d  = matchCnt_q;
        valid_d     = 1'b0;
        locked_d    = locked_q;
        timeout_d   = timeout_q;

        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d   = FIRST;
                    cnt_d     = CNT_ONE;
                    hcnt_d    = CNT_ONE;
                    timeout_d = 1'b0;
                end
            end
            FIRST, TRACK: begin
                // A rise landing on the timeout cycle still counts as a full period.
                if (rise) begin
                    state_d     = TRACK;
                    ratio_d     = cnt_q;
                    highCount_d = hcnt_q;
                    valid_d     = 1'b1;
                    matchCnt_d  = matchNext;
                    locked_d    = (matchNext >= MATCH_MAX);
                    cnt_d       = CNT_ONE;
                    hcnt_d      = CNT_ONE;
                    timeout_d   = 1'b0;
                end else if (timeoutHit) begin
                    state_d    = IDLE;
                    timeout_d  = 1'b1;
                    locked_d   = 1'b0;
                    matchCnt_d = '0;
                    cnt_d      = '0;
                    hcnt_d     = '0;
                end else begin
                    cnt_d  = cntInc;
                    hcnt_d = hcntInc;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clkin) begin
        if (!reset) begin
            state_q     <= IDLE;
            sigDly_q    <= 1'b0;
            cnt_q       <= '0;
            hcnt_q      <= '0;
            ratio_q     <= '0;
            highCount_q <= '0;
            matchCnt_q  <= '0;
            valid_q     <= 1'b0;
            locked_q    <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sigDly_q    <= sig;
            cnt_q       <= cnt_d;
            hcnt_q      <= hcnt_d;
            ratio_q     <= ratio_d;
            highCount_q <= highCount_d;
            matchCnt_q  <= matchCnt_d;
            valid_q     <= valid_d;
            locked_q    <= locked_d;
            timeout_q   <= timeout_d;
        end
    end

    assign ratio      = ratio_q;
    assign high_count = highCount_q;
    assign valid      = valid_q;
    assign locked     = locked_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_clk_ratio_detect.sv
// Directed self-checking bench for clk_ratio_detect: a wide instance with TIMEOUT=100
// and a 4-bit instance with TIMEOUT=15, each fed by a bench-side clock divider.
module tb_clk_ratio_detect;

`ifdef CLK_RATIO_DETECT_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif
    localparam int MAXV = 32;
    localparam int NEXP = 20;

    logic        clkin;
    logic        reset;
    logic        sigInA, sigInB;
    logic [15:0] ratioA, highA;
    logic        validA, lockedA, timeoutA;
    logic [3:0]  ratioB, highB;
    logic        validB, lockedB, timeoutB;

    int checkCount = 0;
    int errCount   = 0;
    int cyc        = 0;

    int ratioDivA = 1, thrA = 0, phaseA = 0;
    int ratioDivB = 1, thrB = 0, phaseB = 0;
    bit enA = 0, enB = 0;

    logic [31:0] obsRatioA [MAXV];
    logic [31:0] obsHighA  [MAXV];
    logic [31:0] obsLockA  [MAXV];
    logic [31:0] obsCycA   [MAXV];
    logic [31:0] obsRatioB [MAXV];
    logic [31:0] obsHighB  [MAXV];
    int nValidA = 0, nValidB = 0;

    int   tRiseCycA = 0, tFallCycA = 0;
    logic tRiseLockedA = 1'bx;
    logic prevTimeoutA = 1'b0, prevTimeoutB = 1'b0;
    int   firstTRiseB = -1, tHighCntB = 0;
    int   eStartCyc = 0, gStartCyc = 0;

    int expRatio [NEXP] = '{3,3,3,3,3,3, 5,5,5,5,5, 8,8,8,8,8, 6,6, 6,6};
    int expHigh  [NEXP] = '{1,1,1,1,1,1, 2,2,2,2,2, 4,4,4,4,4, 3,3, 3,3};
    int expLock  [NEXP] = '{0,0,0,1,1,1, 0,0,0,1,1, 0,0,0,1,1, 0,0, 0,0};

    clk_ratio_detect #(.B(16), .LOCK_COUNT(4), .TIMEOUT(100)) dutA (
        .clkin      (clkin),
        .reset      (reset),
        .sig_in     (sigInA),
        .ratio      (ratioA),
        .high_count (highA),
        .valid      (validA),
        .locked     (lockedA),
        .timeout    (timeoutA)
    );

    clk_ratio_detect #(.B(4), .LOCK_COUNT(4), .TIMEOUT(15)) dutB (
        .clkin      (clkin),
        .reset      (reset),
        .sig_in     (sigInB),
        .ratio      (ratioB),
        .high_count (highB),
        .valid      (validB),
        .locked     (lockedB),
        .timeout    (timeoutB)
    );

    initial clkin = 1'b0;
    always #5 clkin = ~clkin;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic startDivA(input int r, input int t);
        ratioDivA = r; thrA = t; phaseA = 0; enA = 1;
    endtask

    task automatic startDivB(input int r, input int t);
        ratioDivB = r; thrB = t; phaseB = 0; enB = 1;
    endtask

    // Each cycle: sample outputs at the falling edge, then drive the divider outputs.
    task automatic applyStimulus(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clkin);
            cyc++;
            if (validA === 1'b1) begin
                if (nValidA < MAXV) begin
                    obsRatioA[nValidA] = 32'(ratioA);
                    obsHighA[nValidA]  = 32'(highA);
                    obsLockA[nValidA]  = 32'(lockedA);
                    obsCycA[nValidA]   = 32'(cyc);
                end
                nValidA++;
            end
            if (timeoutA === 1'b1 && prevTimeoutA === 1'b0) begin
                tRiseCycA    = cyc;
                tRiseLockedA = lockedA;
            end
            if (timeoutA === 1'b0 && prevTimeoutA === 1'b1) tFallCycA = cyc;
            prevTimeoutA = timeoutA;

            if (validB === 1'b1) begin
                if (nValidB < MAXV) begin
                    obsRatioB[nValidB] = 32'(ratioB);
                    obsHighB[nValidB]  = 32'(highB);
                end
                nValidB++;
            end
            if (timeoutB === 1'b1 && prevTimeoutB === 1'b0 && firstTRiseB < 0) firstTRiseB = cyc;
            if (timeoutB === 1'b1) tHighCntB++;
            prevTimeoutB = timeoutB;

            sigInA = enA && (phaseA < thrA);
            if (enA) phaseA = (phaseA + 1) % ratioDivA;
            sigInB = enB && (phaseB < thrB);
            if (enB) phaseB = (phaseB + 1) % ratioDivB;
        end
    endtask

    initial begin
        reset  = 1'b0;
        sigInA = 1'b0;
        sigInB = 1'b0;
        $display("[TB] start, synchronizer latency %0d", LAT);

        applyStimulus(3);
        checkOutput("rstRatioA",   32'(ratioA),   0);
        checkOutput("rstHighA",    32'(highA),    0);
        checkOutput("rstValidA",   32'(validA),   0);
        checkOutput("rstLockedA",  32'(lockedA),  0);
        checkOutput("rstTimeoutA", 32'(timeoutA), 0);
        checkOutput("rstRatioB",   32'(ratioB),   0);
        checkOutput("rstTimeoutB", 32'(timeoutB), 0);
        reset = 1'b1;

        // Ratio 3 -> 5 -> 8, switched on period boundaries.
        startDivA(3, 1); applyStimulus(18);
        startDivA(5, 2); applyStimulus(25);
        startDivA(8, 4); applyStimulus(48);

        enA = 0; applyStimulus(130);
        eStartCyc = cyc;
        startDivA(6, 3); applyStimulus(16);
        checkOutput("toDelayA",  32'(tRiseCycA) - obsCycA[15], 100);
        checkOutput("toLockedA", 32'(tRiseLockedA), 0);
        checkOutput("toClearA",  32'(tFallCycA - eStartCyc), 32'(2 + LAT));

        // Reset in the middle of a ratio-6 period, released while the divider is low.
        reset = 1'b0;
        applyStimulus(1);
        checkOutput("midRstRatioA",   32'(ratioA),   0);
        checkOutput("midRstHighA",    32'(highA),    0);
        checkOutput("midRstValidA",   32'(validA),   0);
        checkOutput("midRstLockedA",  32'(lockedA),  0);
        checkOutput("midRstTimeoutA", 32'(timeoutA), 0);
        applyStimulus(1);
        reset = 1'b1;
        applyStimulus(16);

        for (int k = 0; k < NEXP; k++) begin
            checkOutput($sformatf("ratioA[%0d]", k),  obsRatioA[k], 32'(expRatio[k]));
            checkOutput($sformatf("highA[%0d]", k),   obsHighA[k],  32'(expHigh[k]));
            checkOutput($sformatf("lockedA[%0d]", k), obsLockA[k],  32'(expLock[k]));
        end
        for (int k = 10; k < 15; k++)
            checkOutput($sformatf("period8A[%0d]", k), obsCycA[k+1] - obsCycA[k], 8);

        // 4-bit instance: ratio 20 must only ever time out, ratio 15 must be measured.
        enA = 0;
        gStartCyc = cyc; firstTRiseB = -1; nValidB = 0;
        startDivB(20, 10); applyStimulus(80);
        checkOutput("validsB20",   32'(nValidB), 0);
        checkOutput("toFirstB20",  32'(firstTRiseB - gStartCyc), 32'(17 + LAT));
        checkOutput("ratioB20",    32'(ratioB), 0);

        nValidB = 0; tHighCntB = 0;
        startDivB(15, 7); applyStimulus(60);
        checkOutput("validsB15", 32'(nValidB), 3);
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("ratioB15[%0d]", k), obsRatioB[k], 15);
            checkOutput($sformatf("highB15[%0d]", k),  obsHighB[k],  7);
        end
        checkOutput("toHighB15", 32'(tHighCntB), 32'(1 + LAT));

        checkOutput("validsA", 32'(nValidA), NEXP);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule

// File: doc/clk_ratio_detect.md
CLK_RATIO_DETECT -- requirements
Module: clk_ratio_detect

Interface
REQ-001 Parameter B, default 16, width of all cycle counters and measurement outputs.
REQ-002 Parameter LOCK_COUNT, default 4, consecutive identical ratio measurements needed to assert locked.
REQ-003 Parameter TIMEOUT, default 2**B-1, clkin cycles without a rising edge before timeout is declared.
REQ-004 clkin  input  1  sole clock, all state updates on posedge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 sig_in  input  1  divided clock under measurement, asynchronous to clkin in general.
REQ-007 ratio  output  B  last measured period, in clkin cycles, rising edge to rising edge.
REQ-008 high_count  output  B  clkin cycles sig was high within that period.
REQ-009 valid  output  1  one-cycle pulse when ratio/high_count update.
REQ-010 locked  output  1  measurement stable.
REQ-011 timeout  output  1  no rising edge within TIMEOUT cycles.

Function
REQ-012 Internal sig (synchronized sig_in) shall feed a registered edge detector; rise = sig & ~sig_d.
REQ-013 State machine shall have states IDLE, FIRST, TRACK.
REQ-014 IDLE: on rise go to FIRST, load cnt<=1, hcnt<=1; no output update.
REQ-015 FIRST/TRACK: each cycle without rise, cnt<=cnt+1 and hcnt<=hcnt+sig, both saturating at 2**B-1.
REQ-016 On rise in FIRST or TRACK: ratio<=cnt, high_count<=hcnt, valid=1 next cycle, cnt<=1, hcnt<=1, state<=TRACK.
REQ-017 Divider of ratio R, threshold T driving sig_in shall yield ratio=R, high_count=T.
REQ-018 Match counter: on each capture, if new ratio equals previous ratio increment (saturate at LOCK_COUNT) else load 1 and deassert locked.
REQ-019 locked shall assert in the cycle valid reports the LOCK_COUNT-th consecutive equal ratio (first capture counts as 1).
REQ-020 When cnt reaches TIMEOUT without rise: timeout<=1, locked<=0, match counter<=0, state<=IDLE; ratio/high_count retained.
REQ-021 timeout shall stay set until the next rise, clearing in that rise's cycle.
REQ-022 Rise and timeout in the same cycle: rise wins (capture performed, timeout not set).
REQ-023 Saturated cnt shall be reported as 2**B-1 if a rise arrives before timeout.

Reset
REQ-024 reset low at a clkin edge shall set state IDLE, cnt=hcnt=0, ratio=high_count=0, valid=0, locked=0, timeout=0, match counter 0, synchronizer and sig_d flops 0.
REQ-025 Reset mid-period shall discard the partial measurement; the first post-reset rise only arms (REQ-014).

Configuration
REQ-026 Macro CLK_RATIO_DETECT_SYNC_EN defined: sig = sig_in through a two-flop synchronizer (two cycles added latency).
REQ-027 Macro undefined: sig = sig_in directly (same-clock-domain use only); measured values identical, valid two cycles earlier.

Structure
REQ-028 Package clk_ratio_pkg shall hold the state enum typedef (IDLE, FIRST, TRACK) and default B, LOCK_COUNT values.
REQ-029 Synchronizer shall be sub-module bit_synchronizer (1-bit, two flops, same active-low synchronous reset), instantiated only under CLK_RATIO_DETECT_SYNC_EN.
REQ-030 Target size 120-400 lines RTL.

Verification
REQ-031 sig_in from clk_divider ratio=3 -> every valid shows ratio=3, high_count=1; locked high on 4th valid.
REQ-032 Divider ratio=8 -> ratio=8, high_count=4; valid pulses exactly every 8 cycles after first capture.
REQ-033 Switch divider 3->5 while locked -> locked drops on first ratio=5 valid, reasserts on 4th consecutive ratio=5 valid.
REQ-034 Hold sig_in low with TIMEOUT=100 -> timeout=1 exactly 100 cycles after last counted cycle, locked=0; next rise clears timeout, no valid until the following rise.
REQ-035 Assert reset mid-period at ratio=6 -> all outputs 0 next cycle; after release first valid appears on second rise with ratio=6.
REQ-036 B=4, TIMEOUT=15, divider ratio 20 -> timeout asserted, no valid with ratio>15.
